// File: rtl/exec_unit_if.sv
// Issue/writeback bundle between the decode stage, exec_unit and the register file.
interface exec_unit_if #(
    parameter int unsigned WIDTH = 4
);
    // Issue side
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [2:0]       rs1_addr;
    logic [2:0]       rs2_addr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [2:0]       rd;
    // Register file write port and status
    logic             we;
    logic [2:0]       write_reg;
    logic [WIDTH-1:0] write_data;
    logic             busy;

    modport master (
        output in_valid, op, rs1_addr, rs2_addr, rs1_data, rs2_data, rd,
        input  in_ready, we, write_reg, write_data, busy
    );

    modport slave (
        input  in_valid, op, rs1_addr, rs2_addr, rs1_data, rs2_data, rd,
        output in_ready, we, write_reg, write_data, busy
    );
endinterface

// File: rtl/exec_unit.sv
// Execute/writeback stage: single-cycle ALU, shift-add MUL, writeback forwarding.
module exec_unit #(
    parameter int unsigned WIDTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    exec_unit_if.slave bus
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mrd_q, mrd_d;
    logic             we_q, we_d;
    logic [2:0]       wreg_q, wreg_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_sum;

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mrd_q    <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mrd_q    <= mrd_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic: IDLE -> MUL on a MUL accept, back after the last iteration
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept && bus.op == 3'b111) state_d = S_MUL;
            S_MUL:   if (cnt_q == LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: ready only in IDLE and never while reset is asserted
    always_comb begin
        ready          = (state_q == S_IDLE) && !rst_n;
        bus.in_ready   = ready;
        bus.busy       = (state_q == S_MUL);
        bus.we         = we_q;
        bus.write_reg  = wreg_q;
        bus.write_data = wdata_q;
    end

    // Operand select with writeback forwarding, then the single-cycle ALU
    always_comb begin
        accept = bus.in_valid && ready;
        op_a = (we_q && wreg_q == bus.rs1_addr && wreg_q != 3'd0) ? wdata_q : bus.rs1_data;
        op_b = (we_q && wreg_q == bus.rs2_addr && wreg_q != 3'd0) ? wdata_q : bus.rs2_data;
        unique case (bus.op)
            3'b000:  alu_res = op_a + op_b;
            3'b001:  alu_res = op_a - op_b;
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = op_a << op_b[SW-1:0];
            3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    // Datapath next values: ALU writeback on accept, one shift-add step per MUL cycle
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mrd_d    = mrd_q;
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.op == 3'b111) begin
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mrd_d    = bus.rd;
                    end else if (bus.rd != 3'd0) begin
                        we_d    = 1'b1;
                        wreg_d  = bus.rd;
                        wdata_d = alu_res;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == LAST && mrd_q != 3'd0) begin
                    we_d    = 1'b1;
                    wreg_d  = mrd_q;
                    wdata_d = acc_sum;
                end
            end
            default: ;
        endcase
    end
endmodule
